uart_rx_frame_router: RTL and testbench
=======================================

Name: uart_rx_frame_router

Overview:
- Sequences received UART bytes into framed packets and steers each frame's payload to one of two consumer channels.
- Sits between the UART receiver byte stream and two downstream consumers, for example a command parser and a data sink.
- Decodes a header byte, forwards N payload bytes with a valid/ready handshake, marks the last byte and aborts stalled frames on timeout.

Parameters:
- DATA_W, 8: byte width; header destination bit is bit DATA_W-1.
- LEN_W, 4: width of the header length field, bits LEN_W-1:0; payload is 0..2^LEN_W-1 bytes.
- TIMEOUT, 1000: number of idle input cycles inside a frame before abort; must be ≥2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  DATA_W  byte from the UART receiver.
- in_valid  in  1  in_data valid.
- in_ready  out  1  router accepts in_data this cycle.
- out_data_0  out  DATA_W  channel 0 payload byte.
- out_valid_0  out  1  channel 0 byte valid.
- out_last_0  out  1  channel 0 byte is the final byte of its frame.
- out_ready_0  in  1  channel 0 consumer accepts.
- out_data_1, out_valid_1, out_last_1, out_ready_1: same as channel 0, for channel 1.
- busy  out  1  state is not IDLE.
- err_timeout  out  1  one-cycle pulse on frame abort.

Behaviour:
- Transfer rule: a transfer occurs when valid and ready are both 1 on a rising clk edge. This applies to the input and to each output.
- Reset values (asynchronous, on rst_n low): all outputs 0 except in_ready, which is 1; state IDLE; all counters 0; holding register empty.
- FSM states are IDLE and PAYLOAD.
- IDLE:
  - in_ready=1.
  - A header transfer latches dest = in_data[DATA_W-1] and remaining = in_data[LEN_W-1:0].
  - If the length is 0, stay in IDLE; the frame is complete and nothing is emitted.
  - Otherwise go to PAYLOAD.
- PAYLOAD:
  - in_ready = !hold_valid || (ready of the channel that owns the holding register).
  - Each accepted byte loads the holding register, tagged with dest and with last = (remaining==1), and decrements remaining.
  - The byte accepted with remaining==1 returns the FSM to IDLE.
- Holding register:
  - One entry, driving only the owning channel: out_valid_d, out_data_d, out_last_d, with d = owner.
  - The non-owning channel has valid=0, data=0, last=0.
  - An empty register drives both channels to 0.
  - Latency: a byte accepted at edge N is visible on the outputs after edge N; it is held until that channel's ready.
  - Drain and refill in the same cycle is allowed, giving full throughput of one byte per cycle.
- Back-to-back frames:
  - A new header may be accepted in IDLE while the previous frame's last byte is still held.
  - New payload waits until the register frees. This holds even if the new dest differs.
  - Bytes are never reordered or duplicated.
- Timeout:
  - The counter counts PAYLOAD cycles where in_ready=1 and in_valid=0.
  - It clears on every input transfer, on entering PAYLOAD and in IDLE.
  - Cycles with in_ready=0 (downstream backpressure) neither count nor clear.
  - On reaching TIMEOUT: pulse err_timeout for 1 cycle, go to IDLE and clear remaining.
  - A byte already in the holding register still drains, with last=0 as originally tagged.
- Simultaneous timeout and input transfer in the same cycle: the transfer wins and the counter clears.
- A reset mid-frame discards the holding register and the FSM state immediately.
- Length field bits above LEN_W-1, excluding bit DATA_W-1, are ignored.

Optional Feature:
Macro ROUTER_STATS_EN.
- When defined, adds outputs:
  - frame_cnt_0 and frame_cnt_1, 16 bits each: completed frames per channel. A frame counts when its last byte is transferred out, or when its zero-length header is accepted.
  - abort_cnt, 8 bits: number of timeouts.
- All counters reset to 0, wrap modulo 2^width and are not affected by backpressure.
- When undefined, these ports and registers do not exist and the rest of the behaviour is identical.

Test Plan:
1. Header 0x83, payload 0x11 0x22 0x33, both out_ready=1, in_valid back-to-back:
   - Channel 1 emits 11, 22, 33 on consecutive cycles; out_last_1 is high only with 0x33.
   - Channel 0 stays 0 throughout; busy falls after the 0x33 transfer.
2. Header 0x02, payload 0xAA 0xBB, with out_ready_0=0 for 5 cycles:
   - 0xAA is held on out_data_0 and in_ready=0.
   - 0xBB is not accepted until out_ready_0 rises.
   - No err_timeout during the stall, even with TIMEOUT=4.
3. TIMEOUT=4, header 0x03, one payload byte 0x55, then in_valid=0:
   - err_timeout pulses exactly 4 idle cycles after the 0x55 transfer.
   - 0x55 drains with last=0; FSM returns to IDLE.
   - The next header 0x81 with payload 0x66 routes to channel 1.
4. Header 0x80 (length 0), then immediately header 0x01 and byte 0x77:
   - No output is produced for the first frame.
   - 0x77 appears on channel 0 with last=1.
   - With ROUTER_STATS_EN: frame_cnt_1=1, frame_cnt_0=1.
5. Frame 0x01/0x99 to channel 0 with out_ready_0=0, followed by header 0x81 and byte 0x44:
   - 0x44 is not accepted until 0x99 drains.
   - 0x44 then appears only on channel 1.
6. Assert rst_n low mid-frame, after header 0x05 and 2 bytes:
   - All outputs go to 0 asynchronously and in_ready=1.
   - After release, header 0x01 with payload 0xC3 gives 0xC3 on channel 0 with last=1.

Source files
------------

// File: rtl/uart_rx_frame_router.sv
// ============================================================================
// uart_rx_frame_router: frames UART bytes (header + N payload) and routes the
// payload to channel 0/1 through a one-entry holding register. Optional
// counters are enabled by the ROUTER_STATS_EN macro.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx_frame_router #(
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data_0,
  output logic              out_valid_0,
  output logic              out_last_0,
  input  logic              out_ready_0,
  output logic [DATA_W-1:0] out_data_1,
  output logic              out_valid_1,
  output logic              out_last_1,
  input  logic              out_ready_1,
  output logic              busy,
  output logic              err_timeout
`ifdef ROUTER_STATS_EN
  ,
  output logic [15:0]       frame_cnt_0,
  output logic [15:0]       frame_cnt_1,
  output logic [7:0]        abort_cnt
`endif
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PAYLOAD = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               dest_q, dest_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0]  hold_data_q, hold_data_d;
  logic               hold_last_q, hold_last_d;
  logic               hold_dest_q, hold_dest_d;
  logic               err_q, err_d;

  logic owner_ready;
  logic drain;
  logic in_xfer;
  logic timeout_hit;
  logic zero_hdr;

  assign owner_ready = hold_dest_q ? out_ready_1 : out_ready_0;
  assign drain       = hold_valid_q && owner_ready;
  assign in_ready    = (state_q == ST_IDLE) ? 1'b1 : (!hold_valid_q || owner_ready);
  assign in_xfer     = in_valid && in_ready;
  // An input transfer always beats a timeout in the same cycle.
  assign timeout_hit = (state_q == ST_PAYLOAD) && in_ready && !in_valid &&
                       (timer_q == TMR_W'(TIMEOUT - 1));
  assign zero_hdr    = (state_q == ST_IDLE) && in_valid &&
                       (in_data[LEN_W-1:0] == '0);

  generate
    if (DATA_W - 2 >= LEN_W) begin : g_unused_hdr
      logic unused_hdr_bits;
      assign unused_hdr_bits = ^in_data[DATA_W-2:LEN_W];
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    dest_d       = dest_q;
    remaining_d  = remaining_q;
    timer_d      = timer_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_last_d  = hold_last_q;
    hold_dest_d  = hold_dest_q;
    err_d        = 1'b0;

    if (drain) begin
      hold_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (in_valid) begin
          dest_d      = in_data[DATA_W-1];
          remaining_d = in_data[LEN_W-1:0];
          if (in_data[LEN_W-1:0] != '0) begin
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (in_xfer) begin
          hold_valid_d = 1'b1;
          hold_data_d  = in_data;
          hold_last_d  = (remaining_q == LEN_W'(1));
          hold_dest_d  = dest_q;
          remaining_d  = remaining_q - LEN_W'(1);
          timer_d      = '0;
          if (remaining_q == LEN_W'(1)) begin
            state_d = ST_IDLE;
          end
        end else if (timeout_hit) begin
          err_d       = 1'b1;
          state_d     = ST_IDLE;
          remaining_d = '0;
          timer_d     = '0;
        end else if (in_ready) begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      dest_q       <= 1'b0;
      remaining_q  <= '0;
      timer_q      <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_last_q  <= 1'b0;
      hold_dest_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      dest_q       <= dest_d;
      remaining_q  <= remaining_d;
      timer_q      <= timer_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_last_q  <= hold_last_d;
      hold_dest_q  <= hold_dest_d;
      err_q        <= err_d;
    end
  end

  // Only the owning channel sees the holding register; the other reads zero.
  assign out_valid_0 = hold_valid_q && !hold_dest_q;
  assign out_data_0  = out_valid_0 ? hold_data_q : '0;
  assign out_last_0  = out_valid_0 && hold_last_q;
  assign out_valid_1 = hold_valid_q && hold_dest_q;
  assign out_data_1  = out_valid_1 ? hold_data_q : '0;
  assign out_last_1  = out_valid_1 && hold_last_q;
  assign busy        = (state_q != ST_IDLE);
  assign err_timeout = err_q;

`ifdef ROUTER_STATS_EN
  logic [15:0] frame_cnt_0_q, frame_cnt_0_d;
  logic [15:0] frame_cnt_1_q, frame_cnt_1_d;
  logic [7:0]  abort_cnt_q, abort_cnt_d;

  // A last-byte drain and a zero-length header can complete two frames at once.
  always_comb begin
    frame_cnt_0_d = frame_cnt_0_q
                  + {15'd0, drain && hold_last_q && !hold_dest_q}
                  + {15'd0, zero_hdr && !in_data[DATA_W-1]};
    frame_cnt_1_d = frame_cnt_1_q
                  + {15'd0, drain && hold_last_q && hold_dest_q}
                  + {15'd0, zero_hdr && in_data[DATA_W-1]};
    abort_cnt_d   = abort_cnt_q + {7'd0, timeout_hit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_0_q <= '0;
      frame_cnt_1_q <= '0;
      abort_cnt_q   <= '0;
    end else begin
      frame_cnt_0_q <= frame_cnt_0_d;
      frame_cnt_1_q <= frame_cnt_1_d;
      abort_cnt_q   <= abort_cnt_d;
    end
  end

  assign frame_cnt_0 = frame_cnt_0_q;
  assign frame_cnt_1 = frame_cnt_1_q;
  assign abort_cnt   = abort_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frame_router.sv
// ============================================================================
// tb_uart_rx_frame_router: table-driven check of framing, routing, stalls,
// timeout, back-to-back frames and asynchronous reset (TIMEOUT=4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_frame_router;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data_0, out_data_1;
  logic       out_valid_0, out_last_0, out_valid_1, out_last_1;
  logic       out_ready_0 = 1'b1;
  logic       out_ready_1 = 1'b1;
  logic       busy, err_timeout;
`ifdef ROUTER_STATS_EN
  logic [15:0] frame_cnt_0, frame_cnt_1;
  logic [7:0]  abort_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_frame_router #(.DATA_W(8), .LEN_W(4), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data_0(out_data_0), .out_valid_0(out_valid_0), .out_last_0(out_last_0),
    .out_ready_0(out_ready_0),
    .out_data_1(out_data_1), .out_valid_1(out_valid_1), .out_last_1(out_last_1),
    .out_ready_1(out_ready_1),
    .busy(busy), .err_timeout(err_timeout)
`ifdef ROUTER_STATS_EN
    , .frame_cnt_0(frame_cnt_0), .frame_cnt_1(frame_cnt_1), .abort_cnt(abort_cnt)
`endif
  );

  // {in_ready, v0, d0, l0, v1, d1, l1, busy, err}
  logic [22:0] act;
  assign act = {in_ready, out_valid_0, out_data_0, out_last_0,
                out_valid_1, out_data_1, out_last_1, busy, err_timeout};

  typedef struct packed {
    logic [7:0]  din;
    logic        vld;
    logic        r0;
    logic        r1;
    logic [22:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [7:0] din, input logic vld,
                              input logic r0, input logic r1, input logic ir,
                              input logic v0, input logic [7:0] d0, input logic l0,
                              input logic v1, input logic [7:0] d1, input logic l1,
                              input logic bsy, input logic err);
    vec_t v;
    v.din = din; v.vld = vld; v.r0 = r0; v.r1 = r1;
    v.exp = {ir, v0, d0, l0, v1, d1, l1, bsy, err};
    return v;
  endfunction

  // Called at posedge+1: drive, compare at negedge, advance past next posedge.
  task automatic run_vec(input vec_t v, input string name);
    in_data = v.din; in_valid = v.vld; out_ready_0 = v.r0; out_ready_1 = v.r1;
    @(negedge clk);
    checks++;
    if (act !== v.exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, v.exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  initial begin
    //         din   v  r0 r1 ir v0 d0   l0 v1 d1   l1 bsy err
    // 1: header 0x83 + 11 22 33 to channel 1
    vecs.push_back(mk(8'h83, 1, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'h11, 1, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(8'h22, 1, 1, 1, 1, 0, 8'h00, 0, 1, 8'h11, 0, 1, 0));
    vecs.push_back(mk(8'h33, 1, 1, 1, 1, 0, 8'h00, 0, 1, 8'h22, 0, 1, 0));
    vecs.push_back(mk(8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 1, 8'h33, 1, 0, 0));
    vecs.push_back(mk(8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
    // 2: header 0x02, AA stalled on channel 0, BB waits
    vecs.push_back(mk(8'h02, 1, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'hAA, 1, 0, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(8'hBB, 1, 0, 1, 0, 1, 8'hAA, 0, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(8'hBB, 1, 1, 1, 1, 1, 8'hAA, 0, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(8'h00, 0, 1, 1, 1, 1, 8'hBB, 1, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
    // 3: header 0x03, one byte 0x55, timeout after 4 idle cycles, then 0x81/66
    vecs.push_back(mk(8'h03, 1, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'h55, 1, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(8'h00, 0, 1, 1, 1, 1, 8'h55, 0, 0, 8'h00, 0, 1, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(8'h81, 1, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1));
    vecs.push_back(mk(8'h66, 1, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 1, 8'h66, 1, 0, 0));
    vecs.push_back(mk(8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
    // 4: zero-length header 0x80, then 0x01/77
    vecs.push_back(mk(8'h80, 1, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'h01, 1, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'h77, 1, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(8'h00, 0, 1, 1, 1, 1, 8'h77, 1, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
    // 5: 0x01/99 held on ch0, header 0x81 accepted, 0x44 waits then goes to ch1
    vecs.push_back(mk(8'h01, 1, 0, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'h99, 1, 0, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(8'h81, 1, 0, 1, 1, 1, 8'h99, 1, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'h44, 1, 0, 1, 0, 1, 8'h99, 1, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(8'h44, 1, 0, 1, 0, 1, 8'h99, 1, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(8'h44, 1, 1, 1, 1, 1, 8'h99, 1, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(8'h00, 0, 1, 0, 1, 0, 8'h00, 0, 1, 8'h44, 1, 0, 0));
    vecs.push_back(mk(8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 1, 8'h44, 1, 0, 0));
    vecs.push_back(mk(8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));

    // Reset state while rst_n is held low
    #2;
    chk("reset_state", {9'd0, act}, {9'd0, 1'b1, 22'd0});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

`ifdef ROUTER_STATS_EN
    chk("frame_cnt_0", {16'd0, frame_cnt_0}, 32'd3);
    chk("frame_cnt_1", {16'd0, frame_cnt_1}, 32'd4);
    chk("abort_cnt",   {24'd0, abort_cnt},   32'd1);
`endif

    // 6: asynchronous reset mid-frame after header 0x05 and two bytes
    run_vec(mk(8'h05, 1, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0), "rst_hdr");
    run_vec(mk(8'h10, 1, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0), "rst_b0");
    run_vec(mk(8'h20, 1, 1, 1, 1, 1, 8'h10, 0, 0, 8'h00, 0, 1, 0), "rst_b1");
    in_valid = 1'b0;
    chk("pre_rst", {9'd0, act}, {9'd0, 1'b1, 1'b1, 8'h20, 1'b0, 9'd0, 1'b0, 1'b1, 1'b0});
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {9'd0, act}, {9'd0, 1'b1, 22'd0});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
`ifdef ROUTER_STATS_EN
    chk("rst_frame_cnt_0", {16'd0, frame_cnt_0}, 32'd0);
`endif
    run_vec(mk(8'h01, 1, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0), "post_hdr");
    run_vec(mk(8'hC3, 1, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0), "post_b0");
    run_vec(mk(8'h00, 0, 1, 1, 1, 1, 8'hC3, 1, 0, 8'h00, 0, 0, 0), "post_out");
    run_vec(mk(8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0), "post_idle");
`ifdef ROUTER_STATS_EN
    chk("post_frame_cnt_0", {16'd0, frame_cnt_0}, 32'd1);
    chk("post_frame_cnt_1", {16'd0, frame_cnt_1}, 32'd0);
    chk("post_abort_cnt",   {24'd0, abort_cnt},   32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
